// File: rtl/bp_update_unit_pkg.sv
// Shared types and constants for the execute-to-branch-predictor update path.
// Defines lane count, PC width, the per-lane resolve bundle and the FIFO/BP entry formats.
package bp_update_unit_pkg;

   localparam int N            = 3;
   localparam int XLEN         = 32;
   localparam int BP_UPD_DEPTH = 8;
   localparam int LANE_CNT_W   = $clog2(N + 1);

   typedef struct packed {
      logic            valid;
      logic            cond;
      logic            taken;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] target;
      logic [XLEN-1:0] pred_npc;
   } BR_RESOLVE_PACKET;

   typedef struct packed {
      logic            cond_branch_en;
      logic            cond_branch_taken;
      logic [XLEN-1:0] PC;
      logic [XLEN-1:0] target_PC;
   } BP_UPD_ENTRY;

   typedef struct packed {
      logic            branch_en;
      logic            cond_branch_en;
      logic            cond_branch_taken;
      logic [XLEN-1:0] PC;
      logic [XLEN-1:0] target_PC;
   } EX_BP_PACKET;

   // Wraps modulo 2^XLEN, so a not-taken branch at the top of memory falls through to 0.
   function automatic logic [XLEN-1:0] calc_npc(input logic [XLEN-1:0] pc,
                                                input logic [XLEN-1:0] target,
                                                input logic            taken);
      return taken ? target : pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// N-in / N-out circular FIFO of branch-predictor training entries.
// Enqueued lanes are compacted into consecutive slots; up to N oldest entries leave per cycle.
module bp_upd_fifo
   import bp_update_unit_pkg::*;
#(
   parameter int DEPTH = BP_UPD_DEPTH,
   parameter int PTR_W = $clog2(DEPTH) + 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   input  logic        [N-1:0]          enq_mask,
   input  BP_UPD_ENTRY [N-1:0]          enq_data,
   output BP_UPD_ENTRY [N-1:0]          deq_data,
   output logic        [LANE_CNT_W-1:0] deq_cnt,
   output logic                         ready
);

   localparam int                AW      = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] N_P     = PTR_W'(N);
   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

   BP_UPD_ENTRY mem [DEPTH];

   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;
   logic [PTR_W-1:0]      count;
   logic [PTR_W-1:0]      free;
   logic [LANE_CNT_W-1:0] enq_cnt;
   logic [N-1:0][AW-1:0]  wr_addr;

   always_comb begin
      count   = tail - head;
      free    = DEPTH_P - count;
      ready   = (free >= N_P);
      deq_cnt = (count >= N_P) ? LANE_CNT_W'(N) : count[LANE_CNT_W-1:0];
      enq_cnt = '0;
      wr_addr = '0;
      // Each enabled lane lands at tail + (number of enabled lanes below it).
      for (int i = 0; i < N; i++) begin
         wr_addr[i] = AW'(tail + PTR_W'(enq_cnt));
         if (enq_mask[i]) enq_cnt = enq_cnt + 1'b1;
      end
      for (int k = 0; k < N; k++) begin
         deq_data[k] = mem[AW'(head + PTR_W'(k))];
      end
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         head <= '0;
         tail <= '0;
      end else begin
         head <= head + PTR_W'(deq_cnt);
         tail <= tail + PTR_W'(enq_cnt);
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < N; i++) begin
         if (enq_mask[i] && !flush && !reset) mem[wr_addr[i]] <= enq_data[i];
      end
   end

endmodule

// File: rtl/bp_update_unit.sv
// Resolves branch lanes, raises a registered redirect on the oldest mispredict and
// streams in-order training updates to the predictor. Optional stats: define BP_UPD_STATS_EN.
module bp_update_unit
   import bp_update_unit_pkg::*;
#(
   parameter int DEPTH = BP_UPD_DEPTH,
   parameter int PTR_W = $clog2(DEPTH) + 1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        squash_in,
   input  logic        [N-1:0]         br_valid_in,
   input  logic        [N-1:0]         br_cond_in,
   input  logic        [N-1:0]         br_taken_in,
   input  logic        [N-1:0][XLEN-1:0] br_pc_in,
   input  logic        [N-1:0][XLEN-1:0] br_target_in,
   input  logic        [N-1:0][XLEN-1:0] br_pred_npc_in,
   output logic                        ready_out,
   output EX_BP_PACKET [N-1:0]         ex_bp_packet_out,
   output logic                        mispredict_out,
   output logic        [XLEN-1:0]      redirect_pc_out
`ifdef BP_UPD_STATS_EN
  ,output logic        [31:0]          stat_resolved_out,
   output logic        [31:0]          stat_mispred_out
`endif
);

   BR_RESOLVE_PACKET [N-1:0]       lanes;
   logic             [N-1:0]       taken;
   logic             [N-1:0][XLEN-1:0] npc;
   logic             [N-1:0]       keep;
   logic             [N-1:0]       enq_mask;
   logic             [N-1:0]       deq_sel;
   logic                           accept;
   logic                           older_mis;
   logic                           any_mis;
   logic             [XLEN-1:0]    redirect_next;
   BP_UPD_ENTRY      [N-1:0]       entries;
   BP_UPD_ENTRY      [N-1:0]       deq_data;
   logic             [LANE_CNT_W-1:0] deq_cnt;

   always_comb begin
      accept        = ready_out && !squash_in;
      older_mis     = 1'b0;
      keep          = '0;
      redirect_next = redirect_pc_out;
      for (int i = 0; i < N; i++) begin
         lanes[i] = '{valid: br_valid_in[i], cond: br_cond_in[i], taken: br_taken_in[i],
                      pc: br_pc_in[i], target: br_target_in[i], pred_npc: br_pred_npc_in[i]};
         taken[i] = !lanes[i].cond || lanes[i].taken;
         npc[i]   = calc_npc(lanes[i].pc, lanes[i].target, taken[i]);
         entries[i] = '{cond_branch_en: lanes[i].cond, cond_branch_taken: taken[i],
                        PC: lanes[i].pc, target_PC: lanes[i].target};
         // Lanes younger than the first mispredict are on the wrong path and are dropped.
         if (lanes[i].valid && !older_mis) begin
            keep[i] = 1'b1;
            if (npc[i] != lanes[i].pred_npc) begin
               older_mis     = 1'b1;
               redirect_next = npc[i];
            end
         end
      end
      enq_mask = accept ? keep : '0;
      any_mis  = accept && older_mis;
      for (int k = 0; k < N; k++) begin
         deq_sel[k] = (LANE_CNT_W'(k) < deq_cnt);
      end
   end

   bp_upd_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .flush    (squash_in),
      .enq_mask (enq_mask),
      .enq_data (entries),
      .deq_data (deq_data),
      .deq_cnt  (deq_cnt),
      .ready    (ready_out)
   );

   // Output stage: redirect strobe and the drained BP packets.
   always_ff @(posedge clock) begin
      if (reset) begin
         mispredict_out   <= 1'b0;
         redirect_pc_out  <= '0;
         ex_bp_packet_out <= '0;
      end else if (squash_in) begin
         mispredict_out   <= 1'b0;
         ex_bp_packet_out <= '0;
      end else begin
         mispredict_out <= any_mis;
         if (any_mis) redirect_pc_out <= redirect_next;
         for (int k = 0; k < N; k++) begin
            if (deq_sel[k]) begin
               ex_bp_packet_out[k] <= '{branch_en: 1'b1,
                                        cond_branch_en: deq_data[k].cond_branch_en,
                                        cond_branch_taken: deq_data[k].cond_branch_taken,
                                        PC: deq_data[k].PC,
                                        target_PC: deq_data[k].target_PC};
            end else begin
               ex_bp_packet_out[k] <= '0;
            end
         end
      end
   end

`ifdef BP_UPD_STATS_EN
   logic [LANE_CNT_W-1:0] acc_cnt;

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [LANE_CNT_W-1:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + 33'(b);
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

   always_comb begin
      acc_cnt = '0;
      for (int i = 0; i < N; i++) begin
         if (enq_mask[i]) acc_cnt = acc_cnt + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stat_resolved_out <= '0;
         stat_mispred_out  <= '0;
      end else begin
         stat_resolved_out <= sat_add(stat_resolved_out, acc_cnt);
         if (any_mis) stat_mispred_out <= sat_add(stat_mispred_out, LANE_CNT_W'(1));
      end
   end
`endif

endmodule

// File: tb/tb_bp_update_unit.sv
// Bench for bp_update_unit: table of hand-derived vectors, corner-case sequences and
// randomized lanes checked against a queue-based reference model.
module tb_bp_update_unit;
   import bp_update_unit_pkg::*;

   localparam int DEPTH = BP_UPD_DEPTH;

   logic                     clock = 1'b0;
   logic                     reset;
   logic                     squash_in;
   logic [N-1:0]             br_valid_in;
   logic [N-1:0]             br_cond_in;
   logic [N-1:0]             br_taken_in;
   logic [N-1:0][XLEN-1:0]   br_pc_in;
   logic [N-1:0][XLEN-1:0]   br_target_in;
   logic [N-1:0][XLEN-1:0]   br_pred_npc_in;
   logic                     ready_out;
   EX_BP_PACKET [N-1:0]      ex_bp_packet_out;
   logic                     mispredict_out;
   logic [XLEN-1:0]          redirect_pc_out;
`ifdef BP_UPD_STATS_EN
   logic [31:0]              stat_resolved_out;
   logic [31:0]              stat_mispred_out;
`endif

   bp_update_unit dut (
      .clock            (clock),
      .reset            (reset),
      .squash_in        (squash_in),
      .br_valid_in      (br_valid_in),
      .br_cond_in       (br_cond_in),
      .br_taken_in      (br_taken_in),
      .br_pc_in         (br_pc_in),
      .br_target_in     (br_target_in),
      .br_pred_npc_in   (br_pred_npc_in),
      .ready_out        (ready_out),
      .ex_bp_packet_out (ex_bp_packet_out),
      .mispredict_out   (mispredict_out),
      .redirect_pc_out  (redirect_pc_out)
`ifdef BP_UPD_STATS_EN
     ,.stat_resolved_out(stat_resolved_out),
      .stat_mispred_out (stat_mispred_out)
`endif
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic v; logic c; logic t;
      logic [31:0] pc; logic [31:0] tgt; logic [31:0] pred;
   } lane_t;

   typedef struct {
      lane_t       l [N];
      logic        exp_mis;
      logic [31:0] exp_rpc;
      logic [N-1:0] exp_acc;
   } vec_t;

   int tests = 0;
   int failed = 0;
   vec_t vecs[$];

   // Reference model state
   EX_BP_PACKET mq[$];
   EX_BP_PACKET m_pkt [N];
   logic        m_mis;
   logic [31:0] m_rpc;
   logic        m_ready;
   logic [31:0] m_res;
   logic [31:0] m_mcnt;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic lane_t mk(input logic v, c, t, input logic [31:0] pc, tgt, pred);
      lane_t l;
      l = '{v: v, c: c, t: t, pc: pc, tgt: tgt, pred: pred};
      return l;
   endfunction

   function automatic logic [31:0] ref_npc(input lane_t l);
      return (!l.c || l.t) ? l.tgt : l.pc + 32'd4;
   endfunction

   function automatic EX_BP_PACKET ref_entry(input lane_t l);
      EX_BP_PACKET p;
      p = '{branch_en: 1'b1, cond_branch_en: l.c, cond_branch_taken: (l.c ? l.t : 1'b1),
            PC: l.pc, target_PC: l.tgt};
      return p;
   endfunction

   function automatic lane_t drv_lane(input int i);
      return mk(br_valid_in[i], br_cond_in[i], br_taken_in[i], br_pc_in[i], br_target_in[i],
                br_pred_npc_in[i]);
   endfunction

   task automatic set_lane(input int i, input lane_t l);
      br_valid_in[i] = l.v; br_cond_in[i] = l.c; br_taken_in[i] = l.t;
      br_pc_in[i] = l.pc; br_target_in[i] = l.tgt; br_pred_npc_in[i] = l.pred;
   endtask

   task automatic clear_lanes();
      for (int i = 0; i < N; i++) set_lane(i, mk(0, 0, 0, 0, 0, 0));
   endtask

   task automatic add_vec(input lane_t a, b, c, input logic mis, input logic [31:0] rpc,
                          input logic [N-1:0] acc);
      vec_t v;
      v.l[0] = a; v.l[1] = b; v.l[2] = c;
      v.exp_mis = mis; v.exp_rpc = rpc; v.exp_acc = acc;
      vecs.push_back(v);
   endtask

   // Model of one clock edge, using the inputs currently driven.
   task automatic model_edge();
      bit room;
      lane_t l;
      if (reset) begin
         mq.delete();
         for (int k = 0; k < N; k++) m_pkt[k] = '0;
         m_mis = 0; m_rpc = 0; m_res = 0; m_mcnt = 0;
      end else if (squash_in) begin
         mq.delete();
         for (int k = 0; k < N; k++) m_pkt[k] = '0;
         m_mis = 0;
      end else begin
         room = (DEPTH - mq.size()) >= N;
         for (int k = 0; k < N; k++) m_pkt[k] = (mq.size() > 0) ? mq.pop_front() : '0;
         m_mis = 0;
         if (room) begin
            for (int i = 0; i < N; i++) begin
               l = drv_lane(i);
               if (l.v) begin
                  mq.push_back(ref_entry(l));
                  if (m_res != 32'hFFFF_FFFF) m_res++;
                  if (ref_npc(l) != l.pred) begin
                     m_mis = 1; m_rpc = ref_npc(l);
                     break;
                  end
               end
            end
         end
         if (m_mis && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
      end
      m_ready = (DEPTH - mq.size()) >= N;
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clock);
      #1;
      chk("ready", 96'(ready_out), 96'(m_ready));
      chk("mispredict", 96'(mispredict_out), 96'(m_mis));
      chk("redirect_pc", 96'(redirect_pc_out), 96'(m_rpc));
      for (int k = 0; k < N; k++)
         chk($sformatf("pkt%0d", k), 96'(ex_bp_packet_out[k]), 96'(m_pkt[k]));
`ifdef BP_UPD_STATS_EN
      chk("stat_resolved", 96'(stat_resolved_out), 96'(m_res));
      chk("stat_mispred", 96'(stat_mispred_out), 96'(m_mcnt));
`endif
   endtask

   function automatic lane_t rand_lane();
      lane_t l;
      l.v = ($urandom_range(0, 9) < 7);
      l.c = 1'($urandom_range(0, 1));
      l.t = 1'($urandom_range(0, 1));
      l.pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      l.tgt = $urandom & 32'hFFFF_FFFE;
      l.pred = ($urandom_range(0, 3) == 0) ? $urandom : ref_npc(l);
      return l;
   endfunction

   initial begin
      lane_t z;
      int slot;
      logic [31:0] base;
      z = mk(0, 0, 0, 0, 0, 0);
      // inputs: lane0, lane1, lane2 ; expected: mispredict, redirect_pc (held if none), accepted lanes
      add_vec(mk(1,0,0,32'h4,32'h18,32'h18), z, z,                                  0, 32'h0,  3'b001);
      add_vec(mk(1,1,0,32'h10,32'h40,32'h40), z, z,                                 1, 32'h14, 3'b001);
      add_vec(mk(1,1,1,32'h100,32'h200,32'h200), mk(1,0,0,32'h10,32'h8,32'h14),
              mk(1,0,0,32'h300,32'h500,32'h500),                                    1, 32'h8,  3'b011);
      add_vec(mk(1,1,0,32'h20,32'h80,32'h24), z, mk(1,0,1,32'h30,32'h50,32'h50),    0, 32'h8,  3'b101);
      add_vec(mk(1,1,1,32'h40,32'h60,32'h44), mk(1,0,0,32'h44,32'h70,32'h70),
              mk(1,0,0,32'h48,32'h90,32'h90),                                       1, 32'h60, 3'b001);
      add_vec(z, mk(1,1,1,32'h70,32'h90,32'h74), mk(1,1,0,32'h90,32'hA0,32'hA0),    1, 32'h90, 3'b010);
      add_vec(mk(1,1,0,32'hFFFF_FFFC,32'h10,32'h0), z, z,                           0, 32'h90, 3'b001);
      add_vec(z, z, z,                                                              0, 32'h90, 3'b000);

      reset = 1; squash_in = 0; clear_lanes();
      cycle(); cycle();
      chk("rst_ready", 96'(ready_out), 96'd1);
      chk("rst_mispredict", 96'(mispredict_out), 96'd0);
      chk("rst_redirect", 96'(redirect_pc_out), 96'd0);
      for (int k = 0; k < N; k++) chk($sformatf("rst_pkt%0d", k), 96'(ex_bp_packet_out[k]), 96'd0);
      reset = 0;

      foreach (vecs[n]) begin
         for (int i = 0; i < N; i++) set_lane(i, vecs[n].l[i]);
         cycle();
         chk($sformatf("vec%0d_mis", n), 96'(mispredict_out), 96'(vecs[n].exp_mis));
         chk($sformatf("vec%0d_rpc", n), 96'(redirect_pc_out), 96'(vecs[n].exp_rpc));
         clear_lanes();
         cycle();
         slot = 0;
         for (int i = 0; i < N; i++) begin
            if (vecs[n].exp_acc[i]) begin
               chk($sformatf("vec%0d_slot%0d", n, slot), 96'(ex_bp_packet_out[slot]),
                   96'(ref_entry(vecs[n].l[i])));
               slot++;
            end
         end
         for (int k = slot; k < N; k++)
            chk($sformatf("vec%0d_slot%0d_zero", n, k), 96'(ex_bp_packet_out[k]), 96'd0);
         cycle();
      end

      // Continuous full-width stream across several pointer wraps.
      base = 32'h1000;
      for (int c = 0; c < 3 * DEPTH; c++) begin
         for (int i = 0; i < N; i++) begin
            set_lane(i, mk(1, 0, 1, base, base + 32'h40, base + 32'h40));
            base = base + 32'd4;
         end
         cycle();
      end
      clear_lanes(); cycle(); cycle();

      // Squash with queued entries and a mispredicting lane in the same cycle.
      for (int i = 0; i < N; i++) set_lane(i, mk(1, 1, 0, 32'h200 + 32'(i*4), 32'h0, 32'h204 + 32'(i*4)));
      cycle();
      squash_in = 1;
      set_lane(0, mk(1, 1, 1, 32'h300, 32'h400, 32'h304));
      cycle();
      chk("sq_mispredict", 96'(mispredict_out), 96'd0);
      chk("sq_ready", 96'(ready_out), 96'd1);
      for (int k = 0; k < N; k++) chk($sformatf("sq_pkt%0d", k), 96'(ex_bp_packet_out[k]), 96'd0);
      squash_in = 0; clear_lanes();
      cycle();
      for (int k = 0; k < N; k++) chk($sformatf("sq_drain%0d", k), 96'(ex_bp_packet_out[k]), 96'd0);

      // Reset mid-operation clears the redirect PC too.
      set_lane(0, mk(1, 0, 0, 32'h500, 32'h600, 32'h504));
      cycle();
      chk("pre_rst_rpc", 96'(redirect_pc_out), 96'h600);
      reset = 1;
      cycle();
      chk("mid_rst_rpc", 96'(redirect_pc_out), 96'd0);
      chk("mid_rst_mis", 96'(mispredict_out), 96'd0);
      reset = 0; clear_lanes();
      cycle();
      for (int k = 0; k < N; k++) chk($sformatf("mid_rst_pkt%0d", k), 96'(ex_bp_packet_out[k]), 96'd0);

`ifdef BP_UPD_STATS_EN
      begin
         logic [31:0] before;
         before = stat_resolved_out;
         set_lane(0, mk(1, 0, 1, 32'h20, 32'h40, 32'h40));
         set_lane(2, mk(1, 0, 1, 32'h24, 32'h80, 32'h80));
         cycle();
         chk("stat_plus2", 96'(stat_resolved_out), 96'(before + 32'd2));
         clear_lanes(); cycle();
      end
`endif

      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) set_lane(i, rand_lane());
         squash_in = ($urandom_range(0, 24) == 0);
         reset = ($urandom_range(0, 149) == 0);
         cycle();
      end
      reset = 0; squash_in = 0; clear_lanes();
      cycle(); cycle();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
